// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and defaults
package pipe_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - combinational N-way word select with out-of-range flag
module mux_nto1
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = 3,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_of_range
);

  // Unused select codes fall through to zero rather than aliasing a source.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign out_of_range = (32'(sel) >= 32'(NUM_IN));

endmodule

// File: rtl/mux_skid_stage.sv
// rtl/mux_skid_stage.sv - N-way operand select into a registered stage with 2-entry skid buffer
module mux_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = 3,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
  input  logic [SEL_W-1:0]        SEL,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    FLUSH,
  output logic [WIDTH-1:0]        OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    SEL_ERR
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             accept;
  logic             pop;

  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data      (IN_DATA),
    .sel          (SEL),
    .out_data     (sel_data),
    .out_of_range (sel_bad)
  );

  // Ready depends only on registered state, so no OUT_READY-to-IN_READY path.
  assign IN_READY  = (state_q != ST_TWO);
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign OUT_DATA  = main_q;
  assign SEL_ERR   = sel_err_q;

  assign accept = IN_VALID & IN_READY;
  assign pop    = OUT_VALID & OUT_READY;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q | (accept & sel_bad);

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = sel_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = sel_data;
        end else if (accept) begin
          skid_d  = sel_data;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops held and incoming entries but keeps the error history.
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule

// File: doc/mux_skid_stage.md
# mux_skid_stage

Parametrised N-way operand select feeding a registered pipeline stage with valid/ready handshake and a 2-entry skid buffer. It generalises the fixed-width 2:1/3:1 select muxes in the RISC-V pipeline datapath to any data width and source count. It adds registered output, backpressure, flush and out-of-range select detection. It sits at pipeline boundaries, for example on forwarded operands into EX, where the downstream stage can stall.

## Interface
Parameters:
- WIDTH, 32, data width of each source and of the output
- NUM_IN, 3, number of selectable sources (≥2)
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden)

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  reset, asynchronous and active-low
- IN_DATA  in  NUM_IN*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH]
- SEL  in  SEL_W  binary source select
- IN_VALID  in  1  upstream offers SEL/IN_DATA
- IN_READY  out  1  stage can accept
- FLUSH  in  1  synchronous discard of all held entries
- OUT_DATA  out  WIDTH  selected data, registered
- OUT_VALID  out  1  OUT_DATA is valid
- OUT_READY  in  1  downstream accepts
- SEL_ERR  out  1  sticky: an accepted transfer had SEL ≥ NUM_IN

## Operation
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- The value captured on accept is IN_DATA[SEL*WIDTH +: WIDTH].
  - If SEL ≥ NUM_IN, the captured value is all-zero and SEL_ERR sets.
  - SEL_ERR clears only on reset; FLUSH does not clear it.
- Storage: main register (drives OUT_DATA) and skid register. The state machine has three states: EMPTY, ONE, TWO.
- EMPTY:
  - accept → ONE; data goes to main.
- ONE:
  - accept & !pop → TWO; data goes to skid.
  - accept & pop → ONE; main loads new data.
  - !accept & pop → EMPTY.
  - no event → hold.
- TWO:
  - IN_READY=0, so no accept is possible.
  - pop → ONE; skid moves to main.
- IN_READY = (state != TWO). It is a function of registered state only, with no combinational path from OUT_READY.
- OUT_VALID = (state != EMPTY).
- OUT_DATA holds stable while OUT_VALID & !OUT_READY.
- FLUSH:
  - Next state is EMPTY and OUT_VALID=0 the following cycle.
  - It overrides a simultaneous accept and pop; the accepted data is dropped, but its SEL_ERR effect is still recorded.
- Data order is strictly FIFO; no entry is lost or duplicated.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, SEL_ERR=0, state EMPTY, skid=0. IN_READY=1 during and after reset.
- Reset asserted mid-operation clears all state immediately (asynchronously); held data is discarded.
- Latency: a transfer accepted on edge n appears on OUT_DATA/OUT_VALID after edge n; one cycle.
- Throughput: 1 transfer/cycle while OUT_READY=1.
- After OUT_READY deasserts, at most one further transfer is accepted (into skid); IN_READY drops the cycle after.
- From TWO, IN_READY rises the cycle after the first pop.
- Full: TWO, IN_READY=0. Empty: EMPTY, OUT_READY ignored.
- Simultaneous accept & pop in ONE: both complete on the same edge; the state stays ONE.

## Structure
- Shared package `pipe_pkg`:
  - state typedef (EMPTY/ONE/TWO, 2-bit)
  - default WIDTH constant (32)
- Sub-module `mux_nto1`:
  - combinational parametrised N-way select (WIDTH, NUM_IN)
  - outputs the selected word and an out-of-range flag
  - also reusable for the other datapath muxes.
- Top level holds the state register, the main/skid registers and the SEL_ERR flop.

## Test plan
- Reset, then WIDTH=32, NUM_IN=3, OUT_READY=1; SEL=0,1,2 on consecutive cycles with sources 0xA, 0xB, 0xC → OUT_DATA 0xA, 0xB, 0xC on the following three cycles with OUT_VALID=1; IN_READY stays 1.
- OUT_READY=0; push 0x11 then 0x22 → IN_READY=0 the cycle after the second accept, OUT_DATA=0x11 holds. Raise OUT_READY → 0x11 then 0x22 emerge, IN_READY=1 after the first pop.
- SEL=3 with NUM_IN=3, IN_DATA nonzero → OUT_DATA=0, SEL_ERR=1. SEL_ERR stays 1 through later legal transfers and FLUSH; it is 0 only after RESET_N pulse.
- State TWO (0x1, 0x2 held); assert FLUSH together with IN_VALID and OUT_READY → next cycle OUT_VALID=0, IN_READY=1, no data emitted.
- RESET_N driven low asynchronously between edges while in ONE → OUT_VALID and OUT_DATA go to 0 immediately, before the next CLK edge.
- Random IN_VALID/OUT_READY over 10k cycles with scoreboard → output sequence equals accepted sequence; OUT_DATA is never changed while stalled.
